i2c_config_sequencer: RTL and testbench

- Control stage directly upstream of the 24-bit I2C sender in the audio path.
- After a start request, it walks a fixed table of WM8731 configuration words. For each word it issues a one-cycle start pulse and holds the word stable until the sender reports completion.
- It inserts a guard gap between transactions and retries a transaction whose completion never arrives.
- It reports completion and error status to the top-level controller, which holds off recording and playback until `o_finished` is high.

---
 rtl/i2c_config_sequencer.sv | 134 +++++++++++++
 tb/tb_i2c_config_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_config_sequencer.sv
// Walks the WM8731 init table: one-cycle start pulse per word, start to pulse is 1 cycle, guard gap between words, timeout/retry per word.
// No backpressure: the word is held until the sender's completion pulse or a timeout, and start requests are only honoured in IDLE/DONE.
module i2c_config_sequencer #(
  parameter int NUM_CMD        = 7,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_i2c_start,
  output logic [23:0] o_i2c_dat,
  input  logic        i_i2c_finished,
  output logic        o_finished,
  output logic        o_error,
  output logic [2:0]  o_cmd_idx
);

  localparam int WW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam int GW = ($clog2(GAP_CYCLES + 1) > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int RW = ($clog2(MAX_RETRY + 1) > 2) ? $clog2(MAX_RETRY + 1) : 2;

  localparam logic [WW-1:0] TIMEOUT_V  = WW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LAST_V = GW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_V    = RW'(MAX_RETRY);
  localparam logic [2:0]    LAST_IDX_V = 3'(NUM_CMD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [WW-1:0] wait_cnt;
  logic [GW-1:0] gap_cnt;
  logic [RW-1:0] retry;

  function automatic logic [23:0] cmd_word(input logic [2:0] i);
    logic [23:0] w;
    case (i)
      3'd0:    w = 24'h341E00;
      3'd1:    w = 24'h340815;
      3'd2:    w = 24'h340A00;
      3'd3:    w = 24'h340C00;
      3'd4:    w = 24'h340E42;
      3'd5:    w = 24'h341019;
      3'd6:    w = 24'h341201;
      default: w = 24'h341E00;
    endcase
    return w;
  endfunction

  assign o_cmd_idx = idx;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= S_IDLE;
      idx         <= 3'd0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      retry       <= '0;
      o_i2c_start <= 1'b0;
      o_i2c_dat   <= 24'h0;
      o_finished  <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_i2c_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state       <= S_WAIT;
            idx         <= 3'd0;
            retry       <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            o_i2c_start <= 1'b1;
            o_i2c_dat   <= cmd_word(3'd0);
            o_finished  <= 1'b0;
            o_error     <= 1'b0;
          end
        end

        S_WAIT: begin
          // A completion on the timeout edge still counts as success.
          if (i_i2c_finished) begin
            wait_cnt <= '0;
            if (idx == LAST_IDX_V) begin
              state      <= S_DONE;
              o_finished <= 1'b1;
              o_error    <= 1'b0;
            end else begin
              state   <= S_GAP;
              idx     <= idx + 3'd1;
              retry   <= '0;
              gap_cnt <= '0;
            end
          end else if (wait_cnt == TIMEOUT_V) begin
            wait_cnt <= '0;
            if (retry == RETRY_V) begin
              state      <= S_DONE;
              o_finished <= 1'b1;
              o_error    <= 1'b1;
            end else begin
              state   <= S_GAP;
              retry   <= retry + 1'b1;
              gap_cnt <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST_V) begin
            state       <= S_WAIT;
            gap_cnt     <= '0;
            wait_cnt    <= '0;
            o_i2c_start <= 1'b1;
            o_i2c_dat   <= cmd_word(idx);
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: model sender answers 110 cycles after each start; expected pulses are queued per scenario.
`timescale 1ns/1ps
module tb_i2c_config_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic        o_i2c_start;
  logic [23:0] o_i2c_dat;
  logic        i_i2c_finished = 1'b0;
  logic        o_finished;
  logic        o_error;
  logic [2:0]  o_cmd_idx;

  always #5 i_clk = ~i_clk;

  i2c_config_sequencer dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .o_i2c_start    (o_i2c_start),
    .o_i2c_dat      (o_i2c_dat),
    .i_i2c_finished (i_i2c_finished),
    .o_finished     (o_finished),
    .o_error        (o_error),
    .o_cmd_idx      (o_cmd_idx)
  );

  typedef struct {
    logic [23:0] dat;
    int          gap;
    logic [2:0]  idx;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          pulse_cnt = 0;
  int          drop_pulse = -1;
  bit          drop_all = 1'b0;
  bit          busy = 1'b0;
  bit          prev_start = 1'b0;
  bit          dat_moved = 1'b0;
  bit          txn_drop = 1'b0;
  int          txn_cyc = 0;
  int          last_start = 0;
  logic [23:0] txn_dat = 24'h0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [23:0] dat, input int gap, input logic [2:0] idx);
    exp_t e;
    e.dat = dat;
    e.gap = gap;
    e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic push_full();
    logic [23:0] words [7];
    words = '{24'h341E00, 24'h340815, 24'h340A00, 24'h340C00, 24'h340E42, 24'h341019, 24'h341201};
    for (int i = 0; i < 7; i++) push(words[i], (i == 0) ? -1 : 114, 3'(i));
  endtask

  // Model sender plus pulse checker: pops the scoreboard on every start pulse.
  task automatic monitor();
    exp_t e;
    forever begin
      tick();
      if (!i_rst) begin
        busy = 1'b0;
        i_i2c_finished = 1'b0;
        prev_start = 1'b0;
      end else begin
        if (i_i2c_finished) i_i2c_finished = 1'b0;
        if (busy) begin
          if (o_i2c_dat !== txn_dat) dat_moved = 1'b1;
          if (cyc - txn_cyc == 109 && !txn_drop) i_i2c_finished = 1'b1;
          if (cyc - txn_cyc == 110) begin
            busy = 1'b0;
            checks++;
            if (dat_moved) begin
              failures++;
              $display("FAIL dat_stable: word %h changed during transaction (now %h)", txn_dat, o_i2c_dat);
            end
          end
        end
        if (prev_start) begin
          checks++;
          if (o_i2c_start !== 1'b0) begin
            failures++;
            $display("FAIL pulse_width: o_i2c_start=%b on 2nd cycle, want 0", o_i2c_start);
          end
        end
        if (o_i2c_start === 1'b1 && !prev_start) begin
          pulse_cnt++;
          checks++;
          if (busy) begin
            failures++;
            $display("FAIL overlap: start pulse at cycle %0d while sender busy since %0d", cyc, txn_cyc);
          end
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: got pulse dat=%h at cycle %0d, want none", o_i2c_dat, cyc);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (o_i2c_dat !== e.dat) begin
              failures++;
              $display("FAIL pulse_dat: got %h want %h", o_i2c_dat, e.dat);
            end
            checks++;
            if (o_cmd_idx !== e.idx) begin
              failures++;
              $display("FAIL pulse_idx: got %0d want %0d", o_cmd_idx, e.idx);
            end
            if (e.gap >= 0) begin
              checks++;
              if (cyc - last_start != e.gap) begin
                failures++;
                $display("FAIL pulse_spacing: got %0d want %0d", cyc - last_start, e.gap);
              end
            end
          end
          busy = 1'b1;
          txn_cyc = cyc;
          txn_dat = o_i2c_dat;
          dat_moved = 1'b0;
          txn_drop = drop_all || (pulse_cnt == drop_pulse);
          last_start = cyc;
        end
        prev_start = (o_i2c_start === 1'b1);
      end
    end
  endtask

  task automatic do_start(input string name);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++;
    if (o_i2c_start !== 1'b1) begin
      failures++;
      $display("FAIL %s_start_latency: o_i2c_start=%b want 1", name, o_i2c_start);
    end
    checks++;
    if (o_finished !== 1'b0) begin
      failures++;
      $display("FAIL %s_finished_clear: o_finished=%b want 0", name, o_finished);
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (o_finished === 1'b1) break;
      tick();
    end
    checks++;
    if (o_finished !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_timeout: o_finished=%b want 1", name, o_finished);
    end
  endtask

  task automatic check_end(input string name, input logic err, input logic [2:0] idx);
    checks++;
    if (o_error !== err) begin
      failures++;
      $display("FAIL %s_error: got %b want %b", name, o_error, err);
    end
    checks++;
    if (o_cmd_idx !== idx) begin
      failures++;
      $display("FAIL %s_cmd_idx: got %0d want %0d", name, o_cmd_idx, idx);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_pulses: %0d pending, want 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (o_i2c_start !== 1'b0 || o_i2c_dat !== 24'h0 || o_finished !== 1'b0 ||
        o_error !== 1'b0 || o_cmd_idx !== 3'd0) begin
      failures++;
      $display("FAIL %s: start=%b dat=%h fin=%b err=%b idx=%0d want all 0",
               name, o_i2c_start, o_i2c_dat, o_finished, o_error, o_cmd_idx);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (3) tick();
    check_zero("reset_values");
    i_rst = 1'b1;
    repeat (10) tick();
    check_zero("idle_no_start");
  endtask

  task automatic test_sequence();
    push_full();
    do_start("seq");
    wait_done("seq");
    check_end("seq", 1'b0, 3'd6);
  endtask

  task automatic test_drop();
    drop_pulse = pulse_cnt + 3;
    push(24'h341E00, -1, 3'd0);
    push(24'h340815, 114, 3'd1);
    push(24'h340A00, 114, 3'd2);
    push(24'h340A00, 260, 3'd2);
    push(24'h340C00, 114, 3'd3);
    push(24'h340E42, 114, 3'd4);
    push(24'h341019, 114, 3'd5);
    push(24'h341201, 114, 3'd6);
    do_start("drop");
    wait_done("drop");
    check_end("drop", 1'b0, 3'd6);
    drop_pulse = -1;
  endtask

  task automatic test_never();
    drop_all = 1'b1;
    push(24'h341E00, -1, 3'd0);
    for (int i = 0; i < 3; i++) push(24'h341E00, 260, 3'd0);
    do_start("never");
    wait_done("never");
    check_end("never", 1'b1, 3'd0);
    drop_all = 1'b0;
  endtask

  task automatic test_ignore_start();
    push_full();
    do_start("restart");
    checks++;
    if (o_error !== 1'b0) begin
      failures++;
      $display("FAIL restart_error_clear: o_error=%b want 0", o_error);
    end
    repeat (50) tick();
    pulse_start();
    repeat (60) tick();
    pulse_start();
    wait_done("ignore");
    check_end("ignore", 1'b0, 3'd6);
  endtask

  task automatic test_reset_mid();
    int base;
    push_full();
    base = pulse_cnt;
    do_start("rstmid");
    for (int i = 0; i < 1000; i++) begin
      if (pulse_cnt >= base + 5) break;
      tick();
    end
    checks++;
    if (pulse_cnt < base + 5) begin
      failures++;
      $display("FAIL rstmid_reach_cmd4: pulses %0d want %0d", pulse_cnt - base, 5);
    end
    repeat (20) tick();
    #2;
    i_rst = 1'b0;
    #1;
    check_zero("rstmid_async_zero");
    exp_q.delete();
    repeat (3) tick();
    i_rst = 1'b1;
    base = pulse_cnt;
    repeat (300) tick();
    checks++;
    if (pulse_cnt != base) begin
      failures++;
      $display("FAIL rstmid_idle: got %0d pulses after release, want 0", pulse_cnt - base);
    end
    push_full();
    do_start("rstmid_restart");
    wait_done("rstmid");
    check_end("rstmid", 1'b0, 3'd6);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_sequence();
    test_drop();
    test_never();
    test_ignore_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
